// File: rtl/vend_seq_ctrl_pkg.sv
// Shared types and constants for the vending sequencing controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int unsigned PRICE0_DEF     = 5;
  localparam int unsigned PRICE1_DEF     = 10;
  localparam int unsigned PRICE2_DEF     = 15;
  localparam int unsigned PRICE3_DEF     = 20;
  localparam int unsigned MAX_CREDIT_DEF = 35;
  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam int unsigned CHG_UNIT       = 5;

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 6'd5;
      COIN_10: coin_value = 6'd10;
      COIN_20: coin_value = 6'd20;
      default: coin_value = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// Customer panel, dispense mechanism and hopper signals of the vending controller.
interface vend_seq_ctrl_if;
  logic       sel_valid;
  logic [1:0] sel_prod;
  logic       sel_ready;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       coin_rej;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_prod;
  logic       disp_ack;
  logic       chg_pulse;
  logic [5:0] credit;
  logic       busy;
  logic       vend_done;
  logic       vend_ok;

  modport slave (
    input  sel_valid, sel_prod, coin_valid, coin_val, cancel, disp_ack,
    output sel_ready, coin_rej, disp_req, disp_prod, chg_pulse, credit, busy,
           vend_done, vend_ok
  );

  modport master (
    output sel_valid, sel_prod, coin_valid, coin_val, cancel, disp_ack,
    input  sel_ready, coin_rej, disp_req, disp_prod, chg_pulse, credit, busy,
           vend_done, vend_ok
  );
endinterface

// File: rtl/vend_seq_ctrl_timer.sv
// Idle timer for coin collection: counts enabled cycles, saturates at TIMEOUT.
module vend_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TC);
endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: latch selection, collect coins, dispense handshake, pay change.
// IDLE wait select | COLLECT take coins | DISPENSE await ack | CHANGE pay out | DONE report
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = PRICE0_DEF,
  parameter int unsigned PRICE1     = PRICE1_DEF,
  parameter int unsigned PRICE2     = PRICE2_DEF,
  parameter int unsigned PRICE3     = PRICE3_DEF,
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  vend_seq_ctrl_if.slave bus
);
  localparam logic [5:0] CHG_STEP   = 6'(CHG_UNIT);
  localparam logic [6:0] CREDIT_CAP = 7'(MAX_CREDIT);

  state_e     state_q, state_d;
  logic [1:0] prod_q, prod_d;
  logic [5:0] price_q, price_d;
  logic [5:0] credit_q, credit_d;
  logic       paid_q, paid_d;
  logic       chg_q, chg_d;
  logic       rej_q, rej_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic       tmr_clr, tmr_en, tmr_expired;
  logic [6:0] coin_sum;
  logic       coin_fits;

  function automatic logic [5:0] price_of(input logic [1:0] prod);
    case (prod)
      2'b00:   price_of = 6'(PRICE0);
      2'b01:   price_of = 6'(PRICE1);
      2'b10:   price_of = 6'(PRICE2);
      default: price_of = 6'(PRICE3);
    endcase
  endfunction

  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Sum is one bit wider than credit so the cap compare never sees a wrapped value.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_val)};
  assign coin_fits = (bus.coin_val != COIN_NONE) && (coin_sum <= CREDIT_CAP);

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    price_d  = price_q;
    credit_d = credit_q;
    paid_d   = paid_q;
    chg_d    = 1'b0;
    rej_d    = 1'b0;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        rej_d   = bus.coin_valid;
        if (bus.sel_valid) begin
          prod_d   = bus.sel_prod;
          price_d  = price_of(bus.sel_prod);
          credit_d = '0;
          paid_d   = 1'b0;
          state_d  = COLLECT;
        end
      end

      COLLECT: begin
        tmr_clr = bus.coin_valid;
        tmr_en  = !bus.coin_valid;
        // Enough credit outranks cancel/timeout; any coin racing a transition bounces.
        if (credit_q >= price_q) begin
          state_d = DISPENSE;
          rej_d   = bus.coin_valid;
        end else if (bus.cancel || tmr_expired) begin
          state_d = CHANGE;
          paid_d  = 1'b0;
          rej_d   = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[5:0];
          end else begin
            rej_d = 1'b1;
          end
        end
      end

      DISPENSE: begin
        rej_d = bus.coin_valid;
        if (bus.disp_ack) begin
          credit_d = credit_q - price_q;
          paid_d   = 1'b1;
          state_d  = CHANGE;
        end
      end

      CHANGE: begin
        rej_d = bus.coin_valid;
        if (credit_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          ok_d    = paid_q;
        end else if (!chg_q) begin
          chg_d    = 1'b1;
          credit_d = credit_q - CHG_STEP;
        end
      end

      DONE: begin
        rej_d   = bus.coin_valid;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      price_q  <= '0;
      credit_q <= '0;
      paid_q   <= 1'b0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      price_q  <= price_d;
      credit_q <= credit_d;
      paid_q   <= paid_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
    end
  end

  assign bus.sel_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.disp_req  = (state_q == DISPENSE);
  assign bus.disp_prod = prod_q;
  assign bus.chg_pulse = chg_q;
  assign bus.credit    = credit_q;
  assign bus.coin_rej  = rej_q;
  assign bus.vend_done = done_q;
  assign bus.vend_ok   = ok_q;
endmodule

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Sequencing controller for the vending datapath.
- Latches a product selection, accepts coins into a credit register, and checks credit against the product price.
- Drives a dispense handshake to the vend mechanism, then pays change back as one pulse per 5-unit coin.
- Sits between the customer panel (select/coin/cancel) and the dispense mechanism and coin hopper.

Parameters:
PRICE0, 5, price of product 2'b00
PRICE1, 10, price of product 2'b01
PRICE2, 15, price of product 2'b10
PRICE3, 20, price of product 2'b11
MAX_CREDIT, 35, max credit held; a coin that would exceed it is rejected
TIMEOUT, 255, idle cycles in COLLECT before automatic refund

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-low reset
sel_valid  in  1  product selection strobe
sel_prod  in  2  selected product code
sel_ready  out  1  high only in IDLE
coin_valid  in  1  one-cycle coin strobe
coin_val  in  2  01=5, 10=10, 11=20, 00=invalid (rejected)
coin_rej  out  1  one-cycle pulse, coin returned unaccepted
cancel  in  1  customer abort
disp_req  out  1  dispense request, held until ack
disp_prod  out  2  product to dispense, stable while disp_req
disp_ack  in  1  mechanism done
chg_pulse  out  1  one pulse = return one 5-unit coin
credit  out  6  current credit (registered)
busy  out  1  high in every state except IDLE
vend_done  out  1  one-cycle transaction-end pulse
vend_ok  out  1  valid with vend_done; 1 = product dispensed, 0 = refund only

Behaviour:
- Reset (rst=0, async): state=IDLE; credit=0; disp_req, chg_pulse, coin_rej, vend_done and vend_ok all 0; disp_prod=0; timer=0.
- All outputs are registered.
- IDLE:
  - sel_ready=1.
  - On sel_valid: latch sel_prod and its price; credit=0; timer=0; next state COLLECT.
  - coin_valid in IDLE -> coin_rej pulse the next cycle.
- COLLECT:
  - Accepted coin: credit+coin <= MAX_CREDIT; credit updates the cycle after coin_valid.
  - Otherwise (overflow or coin_val=00): coin_rej pulses the next cycle and credit is unchanged.
  - Timer resets on any coin_valid and increments otherwise.
  - Transition is evaluated on registered credit: credit >= price -> DISPENSE.
  - cancel=1, or timer==TIMEOUT -> CHANGE with vend_ok flag cleared.
  - Same cycle cancel and coin_valid: cancel wins; the coin is rejected (coin_rej).
  - Same cycle credit>=price and cancel: DISPENSE wins.
- DISPENSE:
  - disp_req=1 and disp_prod=latched product, held until disp_ack sampled high.
  - On that edge: credit <= credit - price, set vend_ok flag, next state CHANGE.
  - cancel is ignored; coins are rejected.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - If credit==0 -> DONE.
  - Otherwise alternate chg_pulse high one cycle, low one cycle; each high cycle decrements credit by 5.
  - Credit is always a multiple of 5, since coins and prices are multiples of 5.
  - Coins are rejected.
- DONE: vend_done=1 for one cycle with vend_ok from the flag, then IDLE.
- Width rules:
  - credit is 6 bits, unsigned.
  - Sum credit+coin is computed at 7 bits before comparing with MAX_CREDIT, so there is no wrap.
  - Subtraction happens only when credit >= price, so there is no underflow.
- Reset mid-transaction clears all state. Credit is lost with no refund; this is the documented behaviour.
- Latency:
  - Exact credit, ack-to-ack: sel_valid -> COLLECT at 1 cycle; final coin -> disp_req 2 cycles later.
  - Change of N units takes 2*N/5 cycles of CHANGE, then 1 cycle of DONE.

Decomposition:
Package vend_pkg holds:
- state enum: IDLE, COLLECT, DISPENSE, CHANGE, DONE
- coin encoding constants and a coin-value decode function
- default price constants

One sub-module, vend_timer: a TIMEOUT counter with clear/enable inputs and an expired output.

Test Plan:
1. Product 00, coin 5 -> credit=5, disp_req asserted, ack -> no chg_pulse, vend_done with vend_ok=1.
2. Product 10 (15), coins 10 then 20 -> credit 30, dispense, credit 15, exactly 3 chg_pulses on alternate cycles, vend_ok=1.
3. Product 11 (20), coins 20 then 20 in COLLECT with ack delayed... the second coin arrives before the DISPENSE transition: credit 20 -> DISPENSE, second coin gets coin_rej. Overflow variant: credit 30, coin 10 -> coin_rej, credit stays 30.
4. Product 01, coin 5, then cancel -> CHANGE, 1 chg_pulse, vend_done with vend_ok=0; cancel+coin in the same cycle -> coin_rej.
5. Product 11, coin 5, no activity for 255 cycles -> auto refund, 1 chg_pulse, vend_ok=0.
6. Reset asserted during DISPENSE with disp_req high -> disp_req drops immediately (async), credit=0, sel_ready=1 after release.
